// File: rtl/m68k_bus_master.sv
// m68k_bus_master: MC68000 asynchronous bus initiator, one read/write bus cycle per request
module m68k_bus_master #(
   parameter int TIMEOUT = 64
) (
   input  logic        clock,
   input  logic        res,
   input  logic        req,
   input  logic        req_we,
   input  logic [22:0] req_addr,
   input  logic        req_uds,
   input  logic        req_lds,
   input  logic [15:0] req_wdata,
   output logic        busy,
   output logic        ack,
   output logic        berr,
   output logic [15:0] rdata,
   output logic [22:0] a,
   output logic        n_as,
   output logic        n_uds,
   output logic        n_lds,
   output logic        r_n_w,
   input  logic        n_dtack,
   input  logic [15:0] d_in,
   output logic [15:0] d_out,
   output logic        d_oe
);
   typedef enum logic [3:0] {IDLE, S0, S1, S2, S3, S4, SW1, SW2, S5, S6, S7, NUL} state_t;
   localparam logic [7:0] TO = 8'(TIMEOUT);
   state_t state_q, state_d;
   logic [22:0] a_q, a_d;
   logic [15:0] wdata_q, wdata_d, d_out_q, d_out_d, rdata_q, rdata_d;
   logic [7:0] cnt_q, cnt_d;
   logic we_q, we_d, uds_q, uds_d, lds_q, lds_d, berr_pend_q, berr_pend_d;
   logic busy_q, busy_d, ack_q, ack_d, berr_q, berr_d;
   logic n_as_q, n_as_d, n_uds_q, n_uds_d, n_lds_q, n_lds_d, r_n_w_q, r_n_w_d, d_oe_q, d_oe_d;
   logic accept, on_bus, data_ph, drive;
   assign busy = busy_q;
   assign ack = ack_q;
   assign berr = berr_q;
   assign rdata = rdata_q;
   assign a = a_q;
   assign n_as = n_as_q;
   assign n_uds = n_uds_q;
   assign n_lds = n_lds_q;
   assign r_n_w = r_n_w_q;
   assign d_out = d_out_q;
   assign d_oe = d_oe_q;
   // next state plus registered bus outputs derived from the state being entered
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (req) state_d = (req_uds | req_lds) ? S0 : NUL;
         S0: state_d = S1;
         S1: state_d = S2;
         S2: state_d = S3;
         S3: state_d = S4;
         S4: state_d = n_dtack ? SW1 : S5;
         SW1: state_d = SW2;
         SW2: state_d = !n_dtack ? S5 : (cnt_q == TO ? S7 : SW1);
         S5: state_d = S6;
         S6: state_d = S7;
         default: state_d = IDLE;
      endcase
      accept = state_q == IDLE && req;
      on_bus = state_d inside {S2, S3, S4, SW1, SW2, S5, S6};
      data_ph = state_d inside {S4, SW1, SW2, S5, S6};
      drive = state_d inside {S3, S4, SW1, SW2, S5, S6, S7};
      a_d = accept ? req_addr : a_q;
      we_d = accept ? req_we : we_q;
      uds_d = accept ? req_uds : uds_q;
      lds_d = accept ? req_lds : lds_q;
      wdata_d = accept ? req_wdata : wdata_q;
      cnt_d = accept ? 8'd0 : (state_q == SW2 && state_d == SW1) ? cnt_q + 8'd1 : cnt_q;
      berr_pend_d = accept ? 1'b0 : (state_q == SW2 && state_d == S7) ? 1'b1 : berr_pend_q;
      n_as_d = ~on_bus;
      n_uds_d = ~((we_q ? data_ph : on_bus) & uds_q);
      n_lds_d = ~((we_q ? data_ph : on_bus) & lds_q);
      r_n_w_d = ~(we_q & (on_bus | state_d == S7));
      d_oe_d = we_q & drive;
      d_out_d = (state_d == S3 && we_q) ? wdata_q : d_out_q;
      rdata_d = (state_q == S6 && !we_q && !berr_pend_q) ? d_in : rdata_q;
      ack_d = state_q == S7 || state_q == NUL;
      berr_d = state_q == NUL || (state_q == S7 && berr_pend_q);
      busy_d = state_d != IDLE;
   end
   // state and output registers with synchronous reset
   always_ff @(posedge clock) begin
      if (res) begin
         state_q <= IDLE;
         a_q <= '0;
         we_q <= 1'b0;
         uds_q <= 1'b0;
         lds_q <= 1'b0;
         wdata_q <= '0;
         cnt_q <= '0;
         berr_pend_q <= 1'b0;
         n_as_q <= 1'b1;
         n_uds_q <= 1'b1;
         n_lds_q <= 1'b1;
         r_n_w_q <= 1'b1;
         d_oe_q <= 1'b0;
         d_out_q <= '0;
         rdata_q <= '0;
         ack_q <= 1'b0;
         berr_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q <= a_d;
         we_q <= we_d;
         uds_q <= uds_d;
         lds_q <= lds_d;
         wdata_q <= wdata_d;
         cnt_q <= cnt_d;
         berr_pend_q <= berr_pend_d;
         n_as_q <= n_as_d;
         n_uds_q <= n_uds_d;
         n_lds_q <= n_lds_d;
         r_n_w_q <= r_n_w_d;
         d_oe_q <= d_oe_d;
         d_out_q <= d_out_d;
         rdata_q <= rdata_d;
         ack_q <= ack_d;
         berr_q <= berr_d;
         busy_q <= busy_d;
      end
   end
endmodule

// File: tb/tb_m68k_bus_master.sv
// tb_m68k_bus_master: directed checks of bus timing, waits, timeout, null request and reset abort
module tb_m68k_bus_master;
   logic clock = 1'b0, res, req, req_we, req_uds, req_lds, n_dtack;
   logic [22:0] req_addr;
   logic [15:0] req_wdata, d_in;
   logic busy, ack, berr, n_as, n_uds, n_lds, r_n_w, d_oe;
   logic [15:0] rdata, d_out;
   logic [22:0] a;
   int checks = 0, errors = 0;
   m68k_bus_master #(.TIMEOUT(4)) dut (
      .clock(clock), .res(res), .req(req), .req_we(req_we), .req_addr(req_addr),
      .req_uds(req_uds), .req_lds(req_lds), .req_wdata(req_wdata), .busy(busy),
      .ack(ack), .berr(berr), .rdata(rdata), .a(a), .n_as(n_as), .n_uds(n_uds),
      .n_lds(n_lds), .r_n_w(r_n_w), .n_dtack(n_dtack), .d_in(d_in), .d_out(d_out),
      .d_oe(d_oe)
   );
   always #5 clock = ~clock;
   task automatic tick();
      @(posedge clock);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask
   initial begin
      res = 1'b1;
      for (int i = 0; i < 3; i++) begin
         req = 1'($urandom);
         req_we = 1'($urandom);
         req_addr = 23'($urandom);
         req_uds = 1'($urandom);
         req_lds = 1'($urandom);
         req_wdata = 16'($urandom);
         n_dtack = 1'($urandom);
         d_in = 16'($urandom);
         tick();
      end
      chk("rst_n_as", 32'(n_as), 32'd1);
      chk("rst_n_uds", 32'(n_uds), 32'd1);
      chk("rst_n_lds", 32'(n_lds), 32'd1);
      chk("rst_r_n_w", 32'(r_n_w), 32'd1);
      chk("rst_d_oe", 32'(d_oe), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);
      chk("rst_a", 32'(a), 32'd0);
      req = 1'b0;
      res = 1'b0;
      tick();
      // zero-wait read
      req = 1'b1; req_we = 1'b0; req_addr = 23'h7FFFF8; req_uds = 1'b1; req_lds = 1'b1;
      n_dtack = 1'b0; d_in = 16'hA55A;
      tick();
      req = 1'b0;
      chk("rd_busy", 32'(busy), 32'd1);
      chk("rd_a", 32'(a), 32'h7FFFF8);
      for (int c = 1; c <= 10; c++) begin
         if (c > 1) tick();
         chk($sformatf("rd_n_as_c%0d", c), 32'(n_as), 32'(!(c >= 3 && c <= 7)));
         chk($sformatf("rd_n_uds_c%0d", c), 32'(n_uds), 32'(!(c >= 3 && c <= 7)));
         chk($sformatf("rd_n_lds_c%0d", c), 32'(n_lds), 32'(!(c >= 3 && c <= 7)));
         chk($sformatf("rd_r_n_w_c%0d", c), 32'(r_n_w), 32'd1);
         chk($sformatf("rd_ack_c%0d", c), 32'(ack), 32'(c == 9));
         chk($sformatf("rd_busy_c%0d", c), 32'(busy), 32'(c <= 8));
      end
      chk("rd_berr", 32'(berr), 32'd0);
      chk("rd_rdata", 32'(rdata), 32'hA55A);
      // write, lower byte only, two wait pairs
      req = 1'b1; req_we = 1'b1; req_addr = 23'h012345; req_uds = 1'b0; req_lds = 1'b1;
      req_wdata = 16'h00C3; n_dtack = 1'b1; d_in = 16'h1111;
      tick();
      req = 1'b0;
      for (int c = 1; c <= 13; c++) begin
         if (c > 1) tick();
         if (c == 8) n_dtack = 1'b0;
         chk($sformatf("wr_r_n_w_c%0d", c), 32'(r_n_w), 32'(!(c >= 3 && c <= 12)));
         chk($sformatf("wr_d_oe_c%0d", c), 32'(d_oe), 32'(c >= 4 && c <= 12));
         chk($sformatf("wr_n_as_c%0d", c), 32'(n_as), 32'(!(c >= 3 && c <= 11)));
         chk($sformatf("wr_n_lds_c%0d", c), 32'(n_lds), 32'(!(c >= 5 && c <= 11)));
         chk($sformatf("wr_n_uds_c%0d", c), 32'(n_uds), 32'd1);
         chk($sformatf("wr_ack_c%0d", c), 32'(ack), 32'(c == 13));
         if (c >= 4 && c <= 12) chk($sformatf("wr_d_out_c%0d", c), 32'(d_out), 32'h00C3);
      end
      chk("wr_berr", 32'(berr), 32'd0);
      chk("wr_rdata", 32'(rdata), 32'hA55A);
      // timeout read with n_dtack never asserted
      n_dtack = 1'b1;
      req = 1'b1; req_we = 1'b0; req_addr = 23'h000100; req_uds = 1'b1; req_lds = 1'b0;
      d_in = 16'hBEEF;
      tick();
      req = 1'b0;
      for (int c = 1; c <= 18; c++) begin
         if (c > 1) tick();
         chk($sformatf("to_n_as_c%0d", c), 32'(n_as), 32'(!(c >= 3 && c <= 15)));
         chk($sformatf("to_ack_c%0d", c), 32'(ack), 32'(c == 17));
         chk($sformatf("to_berr_c%0d", c), 32'(berr), 32'(c == 17));
      end
      chk("to_rdata", 32'(rdata), 32'hA55A);
      // null request, then back-to-back read accepted during the ack cycle
      req = 1'b1; req_uds = 1'b0; req_lds = 1'b0; req_we = 1'b0; req_addr = 23'h000200;
      n_dtack = 1'b0; d_in = 16'h5AA5;
      tick();
      chk("nul_busy", 32'(busy), 32'd1);
      chk("nul_n_as1", 32'(n_as), 32'd1);
      chk("nul_ack1", 32'(ack), 32'd0);
      req_uds = 1'b1; req_lds = 1'b1;
      tick();
      chk("nul_ack", 32'(ack), 32'd1);
      chk("nul_berr", 32'(berr), 32'd1);
      chk("nul_n_as2", 32'(n_as), 32'd1);
      chk("nul_busy2", 32'(busy), 32'd0);
      tick();
      req = 1'b0;
      chk("b2b_busy", 32'(busy), 32'd1);
      chk("b2b_ack", 32'(ack), 32'd0);
      for (int c = 2; c <= 9; c++) begin
         tick();
         chk($sformatf("b2b_n_as_c%0d", c), 32'(n_as), 32'(!(c >= 3 && c <= 7)));
         chk($sformatf("b2b_ack_c%0d", c), 32'(ack), 32'(c == 9));
      end
      chk("b2b_berr", 32'(berr), 32'd0);
      chk("b2b_rdata", 32'(rdata), 32'h5AA5);
      // reset during a wait pair aborts without ack
      n_dtack = 1'b1;
      req = 1'b1; req_we = 1'b0; req_addr = 23'h000300; req_uds = 1'b1; req_lds = 1'b1;
      tick();
      req = 1'b0;
      for (int c = 2; c <= 6; c++) tick();
      chk("abt_n_as_sw1", 32'(n_as), 32'd0);
      res = 1'b1;
      tick();
      res = 1'b0;
      chk("abt_n_as", 32'(n_as), 32'd1);
      chk("abt_busy", 32'(busy), 32'd0);
      chk("abt_ack", 32'(ack), 32'd0);
      chk("abt_rdata", 32'(rdata), 32'd0);
      for (int c = 0; c < 12; c++) begin
         tick();
         chk($sformatf("abt_noack_%0d", c), 32'(ack), 32'd0);
      end
      n_dtack = 1'b0;
      req = 1'b1; req_we = 1'b1; req_addr = 23'h000400; req_uds = 1'b1; req_lds = 1'b1;
      req_wdata = 16'h1234;
      tick();
      req = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         if (c > 1) tick();
         chk($sformatf("new_ack_c%0d", c), 32'(ack), 32'(c == 9));
         chk($sformatf("new_r_n_w_c%0d", c), 32'(r_n_w), 32'(!(c >= 3 && c <= 8)));
      end
      chk("new_berr", 32'(berr), 32'd0);
      chk("new_d_out", 32'(d_out), 32'h1234);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
